// File: rtl/edge_evt_pkg.sv
// Shared types and defaults for the edge event logger.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package edge_evt_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int TS_W_DEF  = 16;

  // Bit 0 marks a rising edge and bit 1 a falling edge, so OR-ing the two
  // strobes gives EVT_BOTH with no extra logic.
  typedef enum logic [1:0] {
    EVT_NONE = 2'b00,
    EVT_RISE = 2'b01,
    EVT_FALL = 2'b10,
    EVT_BOTH = 2'b11
  } evt_type_e;

  // Entry layout at the default timestamp width. A logger built with a
  // different TS_W declares the same layout at its own width.
  typedef struct packed {
    evt_type_e             typ;
    logic [TS_W_DEF-1:0]   ts;
    logic [31:0]           data;
  } evt_entry_t;

endpackage

// File: rtl/edge_event_logger_if.sv
// Event output bus: valid/ready handshake plus type, timestamp and data.
// Latency: n/a (wires only).
// Backpressure: the consumer holds evt_ready low and the producer keeps evt_* stable.
// Ports: master drives evt_valid/evt_type/evt_time/evt_data and samples evt_ready;
// slave is the mirror image.
interface edge_event_logger_if #(
  parameter int TS_W = 16
) ();
  logic            evt_valid;
  logic            evt_ready;
  logic [1:0]      evt_type;
  logic [TS_W-1:0] evt_time;
  logic [31:0]     evt_data;

  modport master (output evt_valid, evt_type, evt_time, evt_data, input evt_ready);
  modport slave  (input evt_valid, evt_type, evt_time, evt_data, output evt_ready);
endinterface

// File: rtl/evt_fifo.sv
// Synchronous show-ahead FIFO of event entries; head_o is the oldest entry.
// Latency: a push is visible at head_o / level_o one cycle later; no bypass.
// Backpressure: a push while full only succeeds if a pop happens in the same cycle.
// Ports: clk, rst (async active-low), clr_i (sync flush), push_i/wr_dat_i,
// pop_i, head_o, full_o, empty_o, level_o.
module evt_fifo
  import edge_evt_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = evt_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  entry_t                 wr_dat_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  // Storage carries no reset; only pointers and occupancy do.
  entry_t mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pop_ok, push_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign head_o  = mem[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is accepted when paired with a pop; a pop on empty is ignored.
  assign pop_ok  = pop_i && !empty_o && !clr_i;
  assign push_ok = push_i && (!full_o || pop_ok) && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      level_d = level_q + LVL_W'(1);
      else if (!push_ok && pop_ok) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/edge_event_logger.sv
// Timestamps edge strobes and queues {type, time, data} events for a consumer.
// Latency: strobe to evt_valid is one cycle; output is show-ahead from the FIFO head.
// Backpressure: evt_ready low holds the head; pushes into a full FIFO are dropped and counted.
// Ports: clk, rst (async active-low), enable, clr, posedge_detection,
// negedge_detection, data_in, evt_bus (master), level, full, empty, drop_cnt.
module edge_event_logger
  import edge_evt_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clr,
  input  logic                   posedge_detection,
  input  logic                   negedge_detection,
  input  logic [31:0]            data_in,
  edge_event_logger_if.master    evt_bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic [7:0]             drop_cnt
);
  typedef struct packed {
    evt_type_e         typ;
    logic [TS_W-1:0]   ts;
    logic [31:0]       data;
  } entry_t;

  logic [TS_W-1:0] ts_q, ts_d;
  logic [7:0]      drop_q, drop_d;
  logic            push, pop, drop;
  entry_t          wr_entry, head;

  assign push = enable && (posedge_detection || negedge_detection) && !clr;
  assign pop  = evt_bus.evt_ready && !empty && !clr;
  // A full FIFO only loses the event when no pop makes room this cycle.
  assign drop = push && full && !pop;

  assign wr_entry.typ  = evt_type_e'({negedge_detection, posedge_detection});
  assign wr_entry.ts   = ts_q;
  assign wr_entry.data = data_in;

  always_comb begin
    ts_d   = ts_q;
    drop_d = drop_q;
    if (clr) begin
      ts_d   = '0;
      drop_d = '0;
    end else begin
      if (enable) ts_d = ts_q + TS_W'(1);
      if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q   <= '0;
      drop_q <= '0;
    end else begin
      ts_q   <= ts_d;
      drop_q <= drop_d;
    end
  end

  evt_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .push_i   (push),
    .wr_dat_i (wr_entry),
    .pop_i    (pop),
    .head_o   (head),
    .full_o   (full),
    .empty_o  (empty),
    .level_o  (level)
  );

  // The unreset storage never leaks out: fields read as zero while empty.
  assign evt_bus.evt_valid = !empty;
  assign evt_bus.evt_type  = empty ? 2'b00 : head.typ;
  assign evt_bus.evt_time  = empty ? '0 : head.ts;
  assign evt_bus.evt_data  = empty ? '0 : head.data;
  assign drop_cnt          = drop_q;

endmodule

// File: tb/tb_edge_event_logger.sv
module tb_edge_event_logger;
  import edge_evt_pkg::*;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clr;
  logic        pos;
  logic        neg;
  logic [31:0] data_in;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic [7:0]  drop_cnt;

  int n_checks;
  int n_fail;

  edge_event_logger_if #(.TS_W(16)) bus ();

  edge_event_logger #(.DEPTH(8), .TS_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .clr               (clr),
    .posedge_detection (pos),
    .negedge_detection (neg),
    .data_in           (data_in),
    .evt_bus           (bus.master),
    .level             (level),
    .full              (full),
    .empty             (empty),
    .drop_cnt          (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", bus.evt_valid); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0b want 0", full); end
    n_checks++; if (bus.evt_type !== 2'b00) begin n_fail++; $display("FAIL rst_type got %0d want 0", bus.evt_type); end
    n_checks++; if (bus.evt_time !== 16'd0) begin n_fail++; $display("FAIL rst_time got %0d want 0", bus.evt_time); end
    n_checks++; if (bus.evt_data !== 32'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", bus.evt_data); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_first_capture();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) step();            // timestamp 0 -> 3
    pos = 1'b1; data_in = 32'h0000_00A5;
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL cap_no_bypass got %0b want 0", bus.evt_valid); end
    step();
    pos = 1'b0;
    n_checks++; if (bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid got %0b want 1", bus.evt_valid); end
    n_checks++; if (bus.evt_type !== 2'b01) begin n_fail++; $display("FAIL cap_type got %0d want 1", bus.evt_type); end
    n_checks++; if (bus.evt_time !== 16'd3) begin n_fail++; $display("FAIL cap_time got %0d want 3", bus.evt_time); end
    n_checks++; if (bus.evt_data !== 32'hA5) begin n_fail++; $display("FAIL cap_data got %h want a5", bus.evt_data); end
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL cap_pop_empty got %0b want 1", empty); end
  endtask

  task automatic test_both();
    pos = 1'b1; neg = 1'b1; data_in = 32'hDEAD_BEEF;
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL both_level0 got %0d want 0", level); end
    step();
    pos = 1'b0; neg = 1'b0;
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL both_level1 got %0d want 1", level); end
    n_checks++; if (bus.evt_type !== 2'b11) begin n_fail++; $display("FAIL both_type got %0d want 3", bus.evt_type); end
    n_checks++; if (bus.evt_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL both_data got %h want deadbeef", bus.evt_data); end
    neg = 1'b1; data_in = 32'h1234;   // lone fall strobe
    step();
    neg = 1'b0;
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    n_checks++; if (bus.evt_type !== 2'b10) begin n_fail++; $display("FAIL fall_type got %0d want 2", bus.evt_type); end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL fall_level got %0d want 1", level); end
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_clr();
    for (int i = 1; i <= 10; i++) begin
      pos = 1'b1; data_in = 32'(i);
      step();
      if (i == 8) begin
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full8 got %0b want 1", full); end
        n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level8 got %0d want 8", level); end
      end
    end
    pos = 1'b0;
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d want 8", level); end
    // head must hold while stalled
    step();
    n_checks++; if (bus.evt_data !== 32'd1) begin n_fail++; $display("FAIL ovf_stall_hold got %0d want 1", bus.evt_data); end
    bus.evt_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (bus.evt_data !== 32'(i)) begin n_fail++; $display("FAIL ovf_order_data[%0d] got %0d want %0d", i, bus.evt_data, i); end
      n_checks++; if (bus.evt_time !== 16'(i - 1)) begin n_fail++; $display("FAIL ovf_order_time[%0d] got %0d want %0d", i, bus.evt_time, i - 1); end
      step();
    end
    bus.evt_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained got %0b want 1", empty); end
  endtask

  task automatic test_full_push_pop();
    do_clr();
    for (int i = 0; i < 8; i++) begin
      pos = 1'b1; data_in = 32'h10 + 32'(i);
      step();
    end
    pos = 1'b1; data_in = 32'h99; bus.evt_ready = 1'b1;
    step();
    pos = 1'b0; bus.evt_ready = 1'b0;
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL fpp_level got %0d want 8", level); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL fpp_drop got %0d want 0", drop_cnt); end
    n_checks++; if (bus.evt_data !== 32'h11) begin n_fail++; $display("FAIL fpp_head got %h want 11", bus.evt_data); end
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_d;
      exp_d = (i < 7) ? 32'h11 + 32'(i) : 32'h99;
      n_checks++; if (bus.evt_data !== exp_d) begin n_fail++; $display("FAIL fpp_drain[%0d] got %h want %h", i, bus.evt_data, exp_d); end
      step();
    end
    bus.evt_ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty got %0b want 1", empty); end
  endtask

  task automatic test_drop_saturate();
    do_clr();
    pos = 1'b1; data_in = 32'h5;
    repeat (8 + 260) step();
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop got %0d want 255", drop_cnt); end
    // clr beats a concurrent strobe
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %0b want 1", empty); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_drop got %0d want 0", drop_cnt); end
    step();
    pos = 1'b0;
    n_checks++; if (bus.evt_time !== 16'd0) begin n_fail++; $display("FAIL clr_ts got %0d want 0", bus.evt_time); end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL clr_next_level got %0d want 1", level); end
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_enable_off();
    do_clr();
    repeat (2) step();           // timestamp 0 -> 2
    pos = 1'b1; data_in = 32'h42;
    step();                      // captures 2, timestamp -> 3
    enable = 1'b0; bus.evt_ready = 1'b1;
    repeat (5) step();           // strobes ignored, pop still works
    bus.evt_ready = 1'b0;
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL en_off_level got %0d want 0", level); end
    enable = 1'b1; data_in = 32'h77;
    step();
    pos = 1'b0;
    n_checks++; if (bus.evt_time !== 16'd3) begin n_fail++; $display("FAIL en_resume_time got %0d want 3", bus.evt_time); end
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL en_resume_level got %0d want 1", level); end
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_clr();
    pos = 1'b1;
    repeat (3) step();
    pos = 1'b0;
    n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL rmid_level3 got %0d want 3", level); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %0b want 0", bus.evt_valid); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL rmid_level got %0d want 0", level); end
    rst = 1'b1;
    pos = 1'b1; data_in = 32'h5A;
    step();                      // first edge with rst high captures
    pos = 1'b0;
    n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL rmid_first_level got %0d want 1", level); end
    n_checks++; if (bus.evt_time !== 16'd0) begin n_fail++; $display("FAIL rmid_first_time got %0d want 0", bus.evt_time); end
    n_checks++; if (bus.evt_data !== 32'h5A) begin n_fail++; $display("FAIL rmid_first_data got %h want 5a", bus.evt_data); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    enable        = 1'b1;
    clr           = 1'b0;
    pos           = 1'b0;
    neg           = 1'b0;
    data_in       = 32'd0;
    bus.evt_ready = 1'b0;

    test_reset();
    test_first_capture();
    test_both();
    test_overflow();
    test_full_push_pop();
    test_drop_saturate();
    test_enable_off();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
